// File: rtl/dna_port_sequencer.sv
// Device-DNA port sequencer: generates the slow DNA clock and READ/SHIFT controls, captures the ID once and
// serves the cached value to NUM_REQ round-robin requesters. Define DNA_DOUBLE_READ_EN for paired reads plus dna_err.
module dna_port_sequencer #(
    parameter int DIV_LOG2 = 4,
    parameter int NUM_REQ  = 2,
    parameter int DNA_W    = 57
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               refresh,
    output logic [NUM_REQ-1:0] done,
    output logic [DNA_W-1:0]   dna,
    output logic               dna_valid,
    output logic               busy,
    output logic               dna_clk,
    output logic               dna_read,
    output logic               dna_shift,
    output logic               dna_din,
    input  logic               dna_dout
`ifdef DNA_DOUBLE_READ_EN
    ,
    output logic               dna_err
`endif
);
    localparam int CW = $clog2(DNA_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_SERVE} state_t;

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    state_t              state_q, state_d;
    logic [DIV_LOG2-1:0] div_q, div_d;
    logic                dna_clk_q, dna_clk_d;
    logic                read_q, read_d, shift_q, shift_d;
    logic                busy_q, busy_d, valid_q, valid_d, pend_q, pend_d;
    logic [DNA_W-1:0]    dna_q, dna_d, shreg_q, shreg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d, rr_mask_q, rr_mask_d;
    logic [NUM_REQ-1:0]  masked_w, pick_w, gnt_w;
    logic                rise_tick, fall_tick, start_w, commit_w;
`ifdef DNA_DOUBLE_READ_EN
    logic [DNA_W-1:0]    cmp_q, cmp_d;
    logic                pass_q, pass_d, retry_q, retry_d, err_q, err_d, restart_w;
`endif

    // Reset asserts asynchronously but is released in step with clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        rise_tick = div_q[DIV_LOG2-1] & ~dna_clk_q;
        fall_tick = ~div_q[DIV_LOG2-1] & dna_clk_q;
        div_d     = div_q + DIV_LOG2'(1);
        dna_clk_d = div_q[DIV_LOG2-1];

        // Round-robin: rr_mask holds the bits at or above the pointer; empty mask wraps to index 0.
        masked_w  = req & rr_mask_q;
        pick_w    = (masked_w != '0) ? masked_w : req;
        gnt_w     = pick_w & (~pick_w + NUM_REQ'(1));
        done_d    = '0;
        rr_mask_d = rr_mask_q;
        if (valid_q && (req != '0)) begin
            done_d    = gnt_w;
            rr_mask_d = ~(gnt_w | (gnt_w - NUM_REQ'(1)));
        end

        state_d  = state_q;
        read_d   = read_q;
        shift_d  = shift_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        dna_d    = dna_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q | refresh;
        start_w  = fall_tick && (((req != '0) && !valid_q) || pend_q);
        commit_w = 1'b0;
`ifdef DNA_DOUBLE_READ_EN
        cmp_d     = cmp_q;
        pass_d    = pass_q;
        retry_d   = retry_q;
        err_d     = err_q;
        restart_w = 1'b0;
`endif

        case (state_q)
            ST_IDLE, ST_SERVE: begin
                if (start_w) begin
                    state_d = ST_LOAD;
                    read_d  = 1'b1;
                    busy_d  = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                    pend_d  = refresh;
`ifdef DNA_DOUBLE_READ_EN
                    pass_d  = 1'b0;
                    retry_d = 1'b0;
`endif
                end else if (req == '0) begin
                    state_d = ST_IDLE;
                end else if (valid_q) begin
                    state_d = ST_SERVE;
                end
            end
            ST_LOAD: begin
                if (fall_tick) begin
                    read_d  = 1'b0;
                    shift_d = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_tick && (cnt_q != CW'(DNA_W))) begin
                    shreg_d = {shreg_q[DNA_W-2:0], dna_dout};
                    cnt_d   = cnt_q + CW'(1);
                end
                if (fall_tick && (cnt_q == CW'(DNA_W))) begin
                    shift_d = 1'b0;
`ifdef DNA_DOUBLE_READ_EN
                    if (!pass_q) begin
                        cmp_d     = shreg_q;
                        pass_d    = 1'b1;
                        restart_w = 1'b1;
                    end else if (shreg_q == cmp_q) begin
                        commit_w = 1'b1;
                        err_d    = 1'b0;
                    end else if (!retry_q) begin
                        retry_d   = 1'b1;
                        pass_d    = 1'b0;
                        restart_w = 1'b1;
                    end else begin
                        commit_w = 1'b1;
                        err_d    = 1'b1;
                    end
                    if (restart_w) begin
                        read_d  = 1'b1;
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
`else
                    commit_w = 1'b1;
`endif
                    if (commit_w) begin
                        dna_d   = shreg_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_SERVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            dna_clk_q <= 1'b0;
            read_q    <= 1'b0;
            shift_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
            dna_q     <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            done_q    <= '0;
            rr_mask_q <= '1;
`ifdef DNA_DOUBLE_READ_EN
            cmp_q     <= '0;
            pass_q    <= 1'b0;
            retry_q   <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            dna_clk_q <= dna_clk_d;
            read_q    <= read_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
            dna_q     <= dna_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rr_mask_q <= rr_mask_d;
`ifdef DNA_DOUBLE_READ_EN
            cmp_q     <= cmp_d;
            pass_q    <= pass_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
`endif
        end
    end

    assign done      = done_q;
    assign dna       = dna_q;
    assign dna_valid = valid_q;
    assign busy      = busy_q;
    assign dna_clk   = dna_clk_q;
    assign dna_read  = read_q;
    assign dna_shift = shift_q;
    assign dna_din   = 1'b0;
`ifdef DNA_DOUBLE_READ_EN
    assign dna_err   = err_q;
`endif

endmodule

// File: doc/dna_port_sequencer.md
Name: dna_port_sequencer

Overview:
- Owns the FPGA device-DNA shift port and sequences it.
- Generates the slow DNA clock, the READ/SHIFT controls, and the 57-bit serial capture.
- Caches the captured ID and shares it between NUM_REQ requesters (e.g. ethernet MAC-address generator, hypervisor registers, licence check) using a round-robin req/done handshake.
- Sits between the DNA_PORT primitive instance and the system-clock consumers.

Parameters:
- DIV_LOG2, 4: DNA clock period = 2^DIV_LOG2 clk cycles (16 → 3.125 MHz at 50 MHz; must keep DNA clock ≤ 2 MHz at the target clk).
- NUM_REQ, 2: number of requesters (1..8).
- DNA_W, 57: ID width.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- req, input, NUM_REQ: per-requester read request, level, held until done.
- refresh, input, 1: one-cycle pulse forcing a fresh hardware read.
- done, output, NUM_REQ: one-cycle per-requester completion pulse.
- dna, output, DNA_W: cached ID.
- dna_valid, output, 1: cache holds a completed read.
- busy, output, 1: hardware read in progress.
- dna_clk, output, 1: registered DNA port clock; drives BUFG→DNA_PORT.CLK.
- dna_read, output, 1: DNA_PORT.READ.
- dna_shift, output, 1: DNA_PORT.SHIFT.
- dna_din, output, 1: DNA_PORT.DIN, constant 0.
- dna_dout, input, 1: DNA_PORT.DOUT.

Behaviour:
- Reset values: dna=0, dna_valid=0, busy=0, done=0, dna_clk=0, dna_read=0, dna_shift=0. Async assert; release synchronous to clk.
- Divider: DIV_LOG2-bit counter, free-running from reset. dna_clk = counter MSB, registered.
  - rise_tick = cycle in which dna_clk goes 0→1.
  - fall_tick = cycle in which dna_clk goes 1→0.
- Control outputs change only on fall_tick, giving half-period setup to the DNA edge. dna_dout is sampled only on rise_tick, i.e. the value present before that rising edge.
- FSM states: IDLE, LOAD, SHIFT, SERVE.
  - IDLE: start a read on the next fall_tick if (any req and !dna_valid) or refresh_pend. On that fall_tick: dna_read=1, busy=1, clear shift register and bit counter, clear refresh_pend → LOAD.
  - LOAD: stays for one rise_tick, which loads the primitive. At the next fall_tick: dna_read=0, dna_shift=1 → SHIFT.
  - SHIFT: on each rise_tick, shreg <= {shreg[DNA_W-2:0], dna_dout}, MSB first, cnt+1. When cnt reaches DNA_W, the next fall_tick sets dna_shift=0, dna <= shreg, dna_valid=1, busy=0 → SERVE.
  - SERVE: while dna_valid, each clk cycle grant the first asserted req at or after the round-robin pointer. Pulse its done for 1 cycle and set the pointer to the granted index+1 (wrapping at NUM_REQ). At most one done per cycle. Returns to IDLE when no req is pending; any new req is served directly from SERVE/IDLE without a hardware read.
- Worst-case read latency from request to dna_valid: (DNA_W+2)·2^DIV_LOG2 clk + 2 (946 clk at defaults).
- req handling:
  - A req dropped before its done loses service; no done is issued.
  - A requester must drop req in the cycle after done; if req is still high, it is served again in round-robin order.
- refresh:
  - During IDLE/SERVE: sets refresh_pend. dna_valid stays 1 and the old dna stays visible until the new read commits. Requests keep being served from the old value.
  - During LOAD/SHIFT: latches refresh_pend; a second read starts after the current one commits.
- Reset mid-read: abort immediately, all outputs to reset values. A new read starts only on the next req or refresh.

Optional Feature:
- Macro: DNA_DOUBLE_READ_EN.
- Defined:
  - Each hardware read runs LOAD/SHIFT twice back-to-back.
  - The first result is held in a compare register; dna commits only if both results match.
  - On mismatch, repeat once more as a pair. If that pair also mismatches, commit the last value and set output dna_err=1, sticky until reset or a successful refresh.
  - Latency roughly doubles.
- Not defined: single read; dna_err port absent.

Test Plan:
- DNA model 57'h0F0E0D0C0B0A090, req=2'b01 after reset → one LOAD pulse then 57 shift samples; dna=57'h0F0E0D0C0B0A090, dna_valid=1, done[0] single pulse within 946 clk.
- After valid, req=2'b11 held → done[0] then done[1] on consecutive cycles, no new dna_read pulse; repeat with pointer at 1 → done[1] first.
- refresh pulse, model changed to 57'h1FFFFFFFFFFFFFF → dna_valid stays 1, old value visible until commit, then dna=57'h1FFFFFFFFFFFFFF; refresh during SHIFT → exactly two reads.
- Check dna_clk period = 16 clk, dna_read/dna_shift edges only coincide with dna_clk falling, and dna_din=0 throughout.
- reset_n low at bit 30 of SHIFT → all outputs 0 immediately; next req → full clean read with the correct value.
- With DNA_DOUBLE_READ_EN, model returns a single corrupted bit on read 1 only → retry, dna correct, dna_err=0; corruption on all reads → dna_err=1.
